lm_sm_sequencer: RTL and testbench

Expands a load-multiple (LM) or store-multiple (SM) instruction into a sequence of single-word memory micro-ops. It sits directly upstream of the memory stage, between execute and memory. Each cycle it drives one access address, write enable, register index and writeback select into the EX/MEM path. It stalls the front end until the whole sequence has issued.

---
 rtl/risc_pkg.sv | 10 +
 rtl/lowest_bit_enc_8.sv | 12 +
 rtl/lm_sm_sequencer.sv | 71 +++++++
 tb/tb_lm_sm_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared opcodes, writeback select encoding and LM/SM sequencer state type
package risc_pkg;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;
  localparam logic [1:0] REG_DST_ALU = 2'b00;
  localparam logic [1:0] REG_DST_MEM = 2'b01;
  localparam logic [1:0] REG_DST_IMM = 2'b10;
  localparam logic [1:0] REG_DST_PC  = 2'b11;
  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} seq_state_t;
endpackage

// File: rtl/lowest_bit_enc_8.sv
// lowest_bit_enc_8: index of the lowest set bit of an 8-bit vector plus an exactly-one-bit-set flag
module lowest_bit_enc_8 (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       one_hot
);
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) idx = vec[i] ? 3'(i) : idx;
    one_hot = (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
  end
endmodule

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands LM/SM register masks into one single-word memory micro-op per cycle
module lm_sm_sequencer
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_sm,
  input  logic [15:0] in_base_addr,
  input  logic [7:0]  in_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_mem_addr,
  output logic [2:0]  out_reg_idx,
  output logic        out_memwrite_enable,
  output logic        out_regwrite_enable,
  output logic [1:0]  out_reg_dst,
  output logic        out_last
);
  seq_state_t  state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [15:0] addr_q, addr_d;
  logic        sm_q, sm_d;
  logic        one_hot;
  lowest_bit_enc_8 u_enc (.vec(mask_q), .idx(out_reg_idx), .one_hot(one_hot));
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    sm_d    = sm_q;
    if (flush) begin
      state_d = ST_IDLE;
      mask_d  = 8'd0;
    end else if (state_q == ST_IDLE) begin
      if (in_valid) begin
        mask_d  = in_mask;
        addr_d  = in_base_addr;
        sm_d    = in_is_sm;
        state_d = (in_mask != 8'd0) ? ST_ISSUE : ST_IDLE;
      end
    end else if (out_ready) begin
      mask_d  = mask_q & (mask_q - 8'd1);
      addr_d  = addr_q + 16'd1;
      state_d = one_hot ? ST_IDLE : ST_ISSUE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= 8'd0;
      addr_q  <= 16'd0;
      sm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      sm_q    <= sm_d;
    end
  end
  always_comb begin
    in_ready            = (state_q == ST_IDLE);
    out_valid           = (state_q == ST_ISSUE);
    out_mem_addr        = addr_q;
    out_memwrite_enable = out_valid & sm_q;
    out_regwrite_enable = out_valid & ~sm_q;
    out_reg_dst         = sm_q ? REG_DST_ALU : REG_DST_MEM;
    out_last            = out_valid & one_hot;
  end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: randomized and directed self-checking bench against a micro-op queue model
module tb_lm_sm_sequencer;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_is_sm, out_ready;
  logic [15:0] in_base_addr;
  logic [7:0] in_mask;
  logic in_ready, out_valid, out_memwrite_enable, out_regwrite_enable, out_last;
  logic [15:0] out_mem_addr;
  logic [2:0] out_reg_idx;
  logic [1:0] out_reg_dst;
  lm_sm_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_sm(in_is_sm), .in_base_addr(in_base_addr), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_mem_addr(out_mem_addr),
    .out_reg_idx(out_reg_idx), .out_memwrite_enable(out_memwrite_enable),
    .out_regwrite_enable(out_regwrite_enable), .out_reg_dst(out_reg_dst), .out_last(out_last)
  );
  always #5 clk = ~clk;
  typedef struct {logic [2:0] idx; logic [15:0] addr; logic last;} uop_t;
  uop_t q[$];
  logic m_sm = 1'b0;
  int n_cmp = 0, n_err = 0, hs = 0, wr_hs = 0;
  localparam logic [25:0] RESET_VEC = {1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 2'b01, 1'b0};
  function automatic logic [25:0] got_vec();
    return {in_ready, out_valid, out_mem_addr, out_reg_idx, out_memwrite_enable,
            out_regwrite_enable, out_reg_dst, out_last};
  endfunction
  function automatic logic [25:0] exp_vec(output logic [25:0] care);
    if (q.size() == 0) begin
      care = {2'b11, 19'h0, 2'b11, 2'b11, 1'b1};
      return {1'b1, 1'b0, 19'h0, 2'b00, m_sm ? 2'b00 : 2'b01, 1'b0};
    end
    care = '1;
    return {1'b0, 1'b1, q[0].addr, q[0].idx, m_sm, ~m_sm, m_sm ? 2'b00 : 2'b01, q[0].last};
  endfunction
  task automatic model_step();
    int n, k;
    if (reset) begin
      q.delete();
      m_sm = 1'b0;
    end else if (flush) q.delete();
    else if (q.size() == 0) begin
      if (in_valid) begin
        m_sm = in_is_sm;
        n = $countones(in_mask);
        k = 0;
        for (int i = 0; i < 8; i++)
          if (in_mask[i]) begin
            q.push_back('{idx: 3'(i), addr: in_base_addr + 16'(k), last: (k == n - 1)});
            k++;
          end
      end
    end else if (out_ready) begin
      void'(q.pop_front());
      hs++;
      if (m_sm) wr_hs++;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic idle_in();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_is_sm = 1'b0;
    in_base_addr = 16'h0; in_mask = 8'h0; out_ready = 1'b1;
  endtask
  task automatic present(input logic sm, input logic [15:0] base, input logic [7:0] mask);
    in_valid = 1'b1; in_is_sm = sm; in_base_addr = base; in_mask = mask;
  endtask
  task automatic test_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (got_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL reset_state got %h exp %h", got_vec(), RESET_VEC);
    end
  endtask
  task automatic test_lm_basic();
    logic [2:0] idxs [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [25:0] ev, care;
    int k = 0, lasts = 0;
    idle_in();
    present(1'b0, 16'h0100, 8'b1010_0101);
    for (int c = 0; c < 7; c++) begin
      ev = exp_vec(care);
      n_cmp++;
      if ((got_vec() & care) !== (ev & care)) begin
        n_err++;
        $display("FAIL lm_basic cyc %0d got %h exp %h", c, got_vec() & care, ev & care);
      end
      if (out_valid) begin
        n_cmp++;
        if (k > 3 || out_reg_idx !== idxs[k] || out_mem_addr !== 16'h0100 + 16'(k) || out_reg_dst !== 2'b01) begin
          n_err++;
          $display("FAIL lm_uop %0d got idx %0d addr %h", k, out_reg_idx, out_mem_addr);
        end
        k++;
        if (out_last) lasts++;
      end
      tick();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (k != 4 || lasts != 1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lm_count got %0d uops %0d lasts ready %b exp 4 1 1", k, lasts, in_ready);
    end
  endtask
  task automatic test_sm_wrap();
    logic [25:0] ev, care;
    int k = 0;
    idle_in();
    present(1'b1, 16'hFFFE, 8'hFF);
    for (int c = 0; c < 11; c++) begin
      ev = exp_vec(care);
      n_cmp++;
      if ((got_vec() & care) !== (ev & care)) begin
        n_err++;
        $display("FAIL sm_wrap cyc %0d got %h exp %h", c, got_vec() & care, ev & care);
      end
      if (out_valid) begin
        n_cmp++;
        if (out_mem_addr !== 16'hFFFE + 16'(k) || out_reg_idx !== 3'(k) || out_memwrite_enable !== 1'b1) begin
          n_err++;
          $display("FAIL sm_uop %0d got idx %0d addr %h we %b", k, out_reg_idx, out_mem_addr, out_memwrite_enable);
        end
        k++;
      end
      tick();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (k != 8) begin
      n_err++;
      $display("FAIL sm_count got %0d exp 8", k);
    end
  endtask
  task automatic test_zero_mask();
    logic [25:0] ev, care;
    idle_in();
    present(1'b0, 16'h1234, 8'h00);
    for (int c = 0; c < 5; c++) begin
      if (c == 3) present(1'b0, 16'h2000, 8'h01);
      ev = exp_vec(care);
      n_cmp++;
      if ((got_vec() & care) !== (ev & care) || (c < 4 && (out_valid !== 1'b0 || in_ready !== 1'b1))) begin
        n_err++;
        $display("FAIL zero_mask cyc %0d got %h exp %h", c, got_vec() & care, ev & care);
      end
      tick();
      if (c != 2) in_valid = 1'b0;
    end
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL zero_follow_done got valid %b ready %b exp 0 1", out_valid, in_ready);
    end
  endtask
  task automatic test_stall();
    logic [25:0] ev, care;
    int held = 0;
    idle_in();
    wr_hs = 0;
    present(1'b1, 16'h0040, 8'h06);
    for (int c = 0; c < 7; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      ev = exp_vec(care);
      n_cmp++;
      if ((got_vec() & care) !== (ev & care)) begin
        n_err++;
        $display("FAIL stall cyc %0d got %h exp %h", c, got_vec() & care, ev & care);
      end
      if (c >= 1 && c <= 4 && out_valid && out_reg_idx == 3'd1 && out_mem_addr == 16'h0040) held++;
      tick();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (wr_hs != 2 || held != 4) begin
      n_err++;
      $display("FAIL stall_count got writes %0d held %0d exp 2 4", wr_hs, held);
    end
  endtask
  task automatic test_flush();
    logic [25:0] ev, care;
    idle_in();
    present(1'b0, 16'h0300, 8'h0F);
    for (int c = 0; c < 6; c++) begin
      flush = (c == 2);
      if (c == 3) present(1'b1, 16'h0500, 8'h01);
      ev = exp_vec(care);
      n_cmp++;
      if ((got_vec() & care) !== (ev & care)) begin
        n_err++;
        $display("FAIL flush cyc %0d got %h exp %h", c, got_vec() & care, ev & care);
      end
      if (c == 3 || c == 4) begin
        n_cmp++;
        if ((c == 3 && (out_valid !== 1'b0 || in_ready !== 1'b1)) ||
            (c == 4 && (out_valid !== 1'b1 || out_reg_idx !== 3'd0 || out_mem_addr !== 16'h0500))) begin
          n_err++;
          $display("FAIL flush_point cyc %0d got valid %b ready %b idx %0d", c, out_valid, in_ready, out_reg_idx);
        end
      end
      tick();
      in_valid = 1'b0;
    end
  endtask
  task automatic test_reset_mid();
    idle_in();
    present(1'b0, 16'h0700, 8'h0F);
    tick();
    tick();
    reset = 1'b1;
    present(1'b1, 16'h0900, 8'hFF);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (got_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL reset_mid got %h exp %h", got_vec(), RESET_VEC);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_no_accept got valid %b ready %b exp 0 1", out_valid, in_ready);
    end
  endtask
  task automatic test_random();
    logic [25:0] ev, care;
    idle_in();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 99) < 60);
      in_is_sm = 1'($urandom);
      in_base_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
      in_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 199) == 0);
      ev = exp_vec(care);
      n_cmp++;
      if ((got_vec() & care) !== (ev & care)) begin
        n_err++;
        $display("FAIL random cyc %0d got %h exp %h", c, got_vec() & care, ev & care);
      end
      tick();
    end
    idle_in();
  endtask
  initial begin
    idle_in();
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_zero_mask();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
